// File: rtl/pid_uk_sum.sv
// pid_uk_sum: output stage of the discrete PID loop.
// Sequences the derivative stage strobes from a sample tick, sums pk + ik + dk
// at full precision, clamps the result to [UMIN, UMAX] and presents uk with a
// one-cycle uk_valid strobe.
// Optional build macro PID_UK_RATE_LIMIT_EN: after clamping, the per-sample step
// of uk is limited to +/-RATE_MAX. Without the macro, uk is the clamped sum.
module pid_uk_sum #(
    parameter int n        = 8,
    parameter int UMAX     = 100,
    parameter int UMIN     = -100,
    parameter int RATE_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic                clear,
    input  logic signed [n-1:0] pk,
    input  logic signed [n-1:0] ik,
    input  logic signed [n-1:0] dk,
    output logic                enable_yk,
    output logic                enable_yk_1,
    output logic                enable_dk,
    output logic                clear_dk,
    output logic signed [n-1:0] uk,
    output logic                uk_valid,
    output logic                sat_hi,
    output logic                sat_lo,
    output logic                overrun
);

    // Clamp limits widened to the sum precision so all comparisons are signed
    // and of equal width.
    localparam logic signed [n+1:0] UMAX_W = (n+2)'(UMAX);
    localparam logic signed [n+1:0] UMIN_W = (n+2)'(UMIN);

    // Parameter sanity: the clamp window must be ordered and representable.
    if (UMIN >= UMAX) begin : g_bad_clamp_order
        $error("pid_uk_sum: UMIN must be below UMAX");
    end
    if ((UMAX > (2 ** (n - 1)) - 1) || (UMIN < -(2 ** (n - 1)))) begin : g_bad_clamp_range
        $error("pid_uk_sum: clamp limits must fit in n bits");
    end
    if (RATE_MAX < 1) begin : g_bad_rate
        $error("pid_uk_sum: RATE_MAX must be positive");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CAP  = 3'd1,
        DIFF = 3'd2,
        MULT = 3'd3,
        SUM  = 3'd4,
        OUT  = 3'd5
    } state_t;

    state_t                state;
    logic signed [n+1:0]   sum_next;
    logic signed [n+1:0]   sum_p0;
    logic signed [n-1:0]   uk_next;

    // Saturate the full-precision sum into the uk range.
    function automatic logic signed [n-1:0] clamp_sum(input logic signed [n+1:0] s);
        if (s > UMAX_W) begin
            return UMAX_W[n-1:0];
        end else if (s < UMIN_W) begin
            return UMIN_W[n-1:0];
        end else begin
            return s[n-1:0];
        end
    endfunction

`ifdef PID_UK_RATE_LIMIT_EN
    localparam logic signed [n:0]   RATE_P = (n+1)'(RATE_MAX);
    localparam logic signed [n:0]   RATE_N = -RATE_P;
    localparam logic signed [n-1:0] RATE_S = n'(RATE_MAX);

    // Limit the step from the previous output; the step is taken at n+1 bits
    // so the difference of two n-bit values cannot wrap.
    function automatic logic signed [n-1:0] rate_limit(input logic signed [n-1:0] target,
                                                       input logic signed [n-1:0] prev);
        logic signed [n:0] delta;
        delta = {target[n-1], target} - {prev[n-1], prev};
        if (delta > RATE_P) begin
            return prev + RATE_S;
        end else if (delta < RATE_N) begin
            return prev - RATE_S;
        end else begin
            return target;
        end
    endfunction
`endif

    // Full-precision sum: two guard bits cover three n-bit operands.
    assign sum_next = {{2{pk[n-1]}}, pk} + {{2{ik[n-1]}}, ik} + {{2{dk[n-1]}}, dk};

    // Next output value: clamped sum, optionally rate-limited against uk.
    always_comb begin
        uk_next = '0;
`ifdef PID_UK_RATE_LIMIT_EN
        uk_next = rate_limit(clamp_sum(sum_next), uk);
`else
        uk_next = clamp_sum(sum_next);
`endif
    end

    // Saturation flags follow the stored sum, so they hold until the next
    // sample and drop whenever the sum register is zeroed.
    assign sat_hi = (sum_p0 > UMAX_W);
    assign sat_lo = (sum_p0 < UMIN_W);

    // Sequencer: state, registered strobes, sum register and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            enable_yk   <= 1'b0;
            enable_yk_1 <= 1'b0;
            enable_dk   <= 1'b0;
            clear_dk    <= 1'b0;
            uk_valid    <= 1'b0;
            overrun     <= 1'b0;
            uk          <= '0;
            sum_p0      <= '0;
        end else if (clear) begin
            // Clear discards any sample in flight and drops a coincident tick.
            state       <= IDLE;
            enable_yk   <= 1'b0;
            enable_yk_1 <= 1'b0;
            enable_dk   <= 1'b0;
            clear_dk    <= 1'b1;
            uk_valid    <= 1'b0;
            overrun     <= 1'b0;
            uk          <= '0;
            sum_p0      <= '0;
        end else begin
            enable_yk   <= 1'b0;
            enable_yk_1 <= 1'b0;
            enable_dk   <= 1'b0;
            clear_dk    <= 1'b0;
            uk_valid    <= 1'b0;

            if (sample_tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state       <= CAP;
                        enable_yk   <= 1'b1;
                        enable_yk_1 <= 1'b1;
                    end
                end
                CAP: begin
                    state <= DIFF;
                end
                DIFF: begin
                    state     <= MULT;
                    enable_dk <= 1'b1;
                end
                MULT: begin
                    state <= SUM;
                end
                SUM: begin
                    // dk is valid from the derivative stage here; uk is
                    // registered together with the sum so it appears in OUT.
                    state    <= OUT;
                    sum_p0   <= sum_next;
                    uk       <= uk_next;
                    uk_valid <= 1'b1;
                end
                OUT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_uk_sum.sv
// tb_pid_uk_sum: directed bench for pid_uk_sum with hand-computed expectations.
// When PID_UK_RATE_LIMIT_EN is defined, expected uk values pass through a
// one-line step limiter applied to the hand-computed clamped value.
module tb_pid_uk_sum;

    localparam int N        = 8;
    localparam int RATE_MAX = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                sample_tick;
    logic                clear;
    logic signed [N-1:0] pk;
    logic signed [N-1:0] ik;
    logic signed [N-1:0] dk;
    logic                enable_yk;
    logic                enable_yk_1;
    logic                enable_dk;
    logic                clear_dk;
    logic signed [N-1:0] uk;
    logic                uk_valid;
    logic                sat_hi;
    logic                sat_lo;
    logic                overrun;

    int checks = 0;
    int errors = 0;
    int model_prev = 0;

    pid_uk_sum #(
        .n(N), .UMAX(100), .UMIN(-100), .RATE_MAX(RATE_MAX)
    ) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .clear(clear),
        .pk(pk), .ik(ik), .dk(dk),
        .enable_yk(enable_yk), .enable_yk_1(enable_yk_1), .enable_dk(enable_dk),
        .clear_dk(clear_dk), .uk(uk), .uk_valid(uk_valid),
        .sat_hi(sat_hi), .sat_lo(sat_lo), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected uk for a new sample whose clamped value is known.
    function automatic int next_uk(input int clamped);
`ifdef PID_UK_RATE_LIMIT_EN
        int delta;
        delta = clamped - model_prev;
        if (delta > RATE_MAX) model_prev = model_prev + RATE_MAX;
        else if (delta < -RATE_MAX) model_prev = model_prev - RATE_MAX;
        else model_prev = clamped;
`else
        model_prev = clamped;
`endif
        return model_prev;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full sample from IDLE; ends in cycle T+6 (IDLE again).
    task automatic do_sample(input string tag, input int p, input int i, input int d,
                             input int clamped, input int hi, input int lo);
        int exp;
        pk = N'(p); ik = N'(i); dk = N'(d);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check({tag, "_cap_yk"}, int'(enable_yk), 1);
        step();
        step();
        check({tag, "_mult_dk"}, int'(enable_dk), 1);
        step();
        check({tag, "_sum_vld"}, int'(uk_valid), 0);
        step();
        exp = next_uk(clamped);
        check({tag, "_vld"}, int'(uk_valid), 1);
        check({tag, "_uk"}, int'(uk), exp);
        check({tag, "_sat_hi"}, int'(sat_hi), hi);
        check({tag, "_sat_lo"}, int'(sat_lo), lo);
        step();
        check({tag, "_vld_drop"}, int'(uk_valid), 0);
        check({tag, "_uk_hold"}, int'(uk), exp);
    endtask

    initial begin
        int exp;
        int vcount;
        reset = 1'b1; sample_tick = 1'b0; clear = 1'b0;
        pk = '0; ik = '0; dk = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_uk", int'(uk), 0);
        check("rst_vld", int'(uk_valid), 0);
        check("rst_strobes", int'({enable_yk, enable_yk_1, enable_dk, clear_dk}), 0);
        check("rst_sat", int'({sat_hi, sat_lo}), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        step();

        // Basic sample with every strobe checked cycle by cycle.
        pk = 8'sd10; ik = 8'sd20; dk = 8'sd5;
        sample_tick = 1'b1;
        step();                                  // T+1 CAP
        sample_tick = 1'b0;
        check("t1_strobes", int'({enable_yk, enable_yk_1, enable_dk, clear_dk}), 4'b1100);
        step();                                  // T+2 DIFF
        check("t2_strobes", int'({enable_yk, enable_yk_1, enable_dk, clear_dk}), 4'b0000);
        step();                                  // T+3 MULT
        check("t3_strobes", int'({enable_yk, enable_yk_1, enable_dk, clear_dk}), 4'b0010);
        step();                                  // T+4 SUM
        check("t4_strobes", int'({enable_yk, enable_yk_1, enable_dk, clear_dk}), 4'b0000);
        check("t4_vld", int'(uk_valid), 0);
        step();                                  // T+5 OUT
        exp = next_uk(35);
        check("t5_vld", int'(uk_valid), 1);
        check("t5_uk", int'(uk), exp);
        check("t5_sat", int'({sat_hi, sat_lo}), 0);
        step();                                  // T+6 IDLE
        check("t6_vld", int'(uk_valid), 0);
        check("t6_uk", int'(uk), exp);

        // Asynchronous reset in the middle of MULT.
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        check("rm_mult_dk", int'(enable_dk), 1);
        #2;
        reset = 1'b1;
        #1;
        model_prev = 0;
        check("rm_async_uk", int'(uk), 0);
        check("rm_async_strobes", int'({enable_yk, enable_yk_1, enable_dk, clear_dk, uk_valid}), 0);
        step();
        step();
        reset = 1'b0;
        vcount = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (uk_valid || enable_yk) vcount++;
        end
        check("rm_no_activity", vcount, 0);
        check("rm_uk_zero", int'(uk), 0);

        // Overrun: second tick during MULT, then a legal tick at T+6.
        pk = 8'sd10; ik = 8'sd20; dk = 8'sd5;
        sample_tick = 1'b1;
        step();                                  // T+1
        sample_tick = 1'b0;
        check("ov_t1", int'(overrun), 0);
        step();                                  // T+2
        step();                                  // T+3
        sample_tick = 1'b1;
        step();                                  // T+4
        sample_tick = 1'b0;
        check("ov_set", int'(overrun), 1);
        check("ov_t4_vld", int'(uk_valid), 0);
        step();                                  // T+5
        exp = next_uk(35);
        check("ov_t5_vld", int'(uk_valid), 1);
        check("ov_t5_uk", int'(uk), exp);
        step();                                  // T+6
        check("ov_t6_vld", int'(uk_valid), 0);
        check("ov_sticky", int'(overrun), 1);
        sample_tick = 1'b1;
        step();                                  // T+7 = CAP of new sample
        sample_tick = 1'b0;
        check("ov_t7_cap", int'(enable_yk), 1);
        check("ov_t7_sticky", int'(overrun), 1);
        step();
        step();
        step();
        check("ov_t10_vld", int'(uk_valid), 0);
        step();                                  // T+11 OUT of new sample
        exp = next_uk(35);
        check("ov_t11_vld", int'(uk_valid), 1);
        check("ov_t11_uk", int'(uk), exp);
        step();

        // Clamp boundaries.
        do_sample("sat_max", 127, 127, 127, 100, 1, 0);
        do_sample("sat_min", -128, -128, -128, -100, 0, 1);
        do_sample("eq_umax", 50, 30, 20, 100, 0, 0);
        do_sample("umax_p1", 51, 30, 20, 100, 1, 0);
        do_sample("eq_umin", -50, -30, -20, -100, 0, 0);
        do_sample("umin_m1", -51, -30, -20, -100, 0, 1);
        do_sample("sat_max2", 127, 127, 127, 100, 1, 0);

        // Clear during SUM: discards the sample, zeroes uk, flags and overrun.
        pk = 8'sd10; ik = 8'sd20; dk = 8'sd5;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        step();                                  // T+4 SUM
        check("clr_pre_sat_hi", int'(sat_hi), 1);
        check("clr_pre_overrun", int'(overrun), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_prev = 0;
        check("clr_uk", int'(uk), 0);
        check("clr_vld", int'(uk_valid), 0);
        check("clr_overrun", int'(overrun), 0);
        check("clr_sat", int'({sat_hi, sat_lo}), 0);
        check("clr_dk_pulse", int'(clear_dk), 1);
        step();
        check("clr_dk_drop", int'(clear_dk), 0);
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            if (uk_valid) vcount++;
            step();
        end
        check("clr_no_vld", vcount, 0);

        // Clear coincident with a tick: tick dropped, no overrun.
        clear = 1'b1;
        sample_tick = 1'b1;
        step();
        clear = 1'b0;
        sample_tick = 1'b0;
        check("ct_no_cap", int'(enable_yk), 0);
        check("ct_clear_dk", int'(clear_dk), 1);
        check("ct_overrun", int'(overrun), 0);
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (uk_valid || enable_yk) vcount++;
        end
        check("ct_idle", vcount, 0);
        check("ct_overrun_hold", int'(overrun), 0);

        // Step toward a target of 60 from uk = 0.
        do_sample("step1", 30, 20, 10, 60, 0, 0);
        do_sample("step2", 30, 20, 10, 60, 0, 0);
        do_sample("step3", 30, 20, 10, 60, 0, 0);
        do_sample("step4", 30, 20, 10, 60, 0, 0);
`ifdef PID_UK_RATE_LIMIT_EN
        check("rate_final", int'(uk), 60);
`else
        check("direct_final", int'(uk), 60);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pid_uk_sum.md
Name: pid_uk_sum

Overview:
- Downstream neighbour of the derivative (dk) stage in the discrete PID loop.
- Sequences the dk stage's enable and clear strobes from a sample tick.
- Sums the proportional (pk), integral (ik) and derivative (dk) terms, saturates the result and presents the control output uk with a one-cycle valid strobe.
- Feeds the actuator/PWM stage.

Parameters:
- n, 8, width of pk/ik/dk/uk (two's complement).
- UMAX, 100, upper clamp for uk (signed, must fit n bits).
- UMIN, -100, lower clamp for uk (signed, UMIN < UMAX).
- RATE_MAX, 16, max |uk step| per sample; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle strobe: new yk is present on the dk stage input.
- clear  in  1  synchronous loop clear.
- pk  in  n  signed proportional term, valid in SUM state.
- ik  in  n  signed integral term, valid in SUM state.
- dk  in  n  signed derivative term from the dk stage.
- enable_yk  out  1  to dk stage: capture yk.
- enable_yk_1  out  1  to dk stage: shift yk into yk_1.
- enable_dk  out  1  to dk stage: load dk output register.
- clear_dk  out  1  to dk stage: zero dk register.
- uk  out  n  signed saturated control output.
- uk_valid  out  1  one-cycle strobe: uk updated.
- sat_hi  out  1  last uk was clamped at UMAX.
- sat_lo  out  1  last uk was clamped at UMIN.
- overrun  out  1  sticky: sample_tick arrived while busy.

Behaviour:
- Reset (async): FSM=IDLE; uk=0, uk_valid=0, sat_hi=sat_lo=0, overrun=0; all dk-stage strobes 0; internal sum register=0.
- FSM states: IDLE, CAP, DIFF, MULT, SUM, OUT.
  - IDLE: wait for sample_tick; on tick go to CAP next cycle.
  - CAP: enable_yk=1 and enable_yk_1=1 in the same cycle, so the dk stage shifts the old yk and captures the new one. Go to DIFF.
  - DIFF: no strobes; the dk stage registers the difference. Go to MULT.
  - MULT: enable_dk=1. Go to SUM.
  - SUM: sum register <= sign-extended pk + ik + dk, computed at n+2 bits (no overflow possible). Go to OUT.
  - OUT: uk <= clamp(sum, UMIN, UMAX), registered. sat_hi/sat_lo updated. uk_valid=1 for this cycle only. Go to IDLE.
- All FSM outputs are registered-state decodes (Moore); each strobe is high for exactly one cycle.
- Latency: tick sampled in cycle T gives CAP=T+1, DIFF=T+2, MULT=T+3, SUM=T+4. uk and uk_valid are visible in cycle T+5.
- Back-to-back: a tick accepted in IDLE in cycle T+6 is legal. Minimum sample period is 6 cycles.
- Tick in any non-IDLE state: ignored, overrun<=1 (sticky). Cleared only by reset or clear.
- clear: highest priority after reset, valid in any state.
  - Next edge: FSM=IDLE, uk=0, sat flags=0, overrun=0, sum register=0.
  - clear_dk=1 for exactly one cycle (the cycle after clear is sampled).
  - Any in-flight sample is discarded; no uk_valid for it.
- clear and sample_tick in the same cycle: clear wins; the tick is dropped and does not set overrun.
- Clamp boundaries: sum==UMAX passes unclamped with sat_hi=0; sum==UMAX+1 gives uk=UMAX, sat_hi=1. The same rule applies symmetrically at UMIN.
- uk holds its value between uk_valid strobes.

Optional Feature:
- Macro: PID_UK_RATE_LIMIT_EN.
- Defined: after clamping, the step from the previous uk is limited to ±RATE_MAX. uk_new = uk_prev + sign(delta)*min(|delta|, RATE_MAX), where delta = clamped - uk_prev, computed at n+1 bits.
  - Limiting does not set sat flags.
  - clear/reset set uk_prev=0.
- Undefined: uk = clamped value directly. No extra registers or logic.

Test Plan:
- Reset mid-MULT: assert reset -> uk=0, all strobes 0 immediately; FSM IDLE; no uk_valid after release.
- Tick with pk=10, ik=20, dk=5 -> CAP/DIFF/MULT strobes at T+1/T+2/T+3 exactly once; uk=35, uk_valid high only at T+5, sat flags 0.
- pk=127, ik=127, dk=127 -> uk=100, sat_hi=1. Repeat with pk=ik=dk=-128 -> uk=-100, sat_lo=1. Sum exactly 100 -> uk=100, sat_hi=0.
- Tick at T, second tick at T+3 -> overrun=1 and stays set; only one uk_valid. A tick at T+6 is accepted normally.
- clear during SUM with uk=35 previously -> next cycle uk=0, overrun=0, clear_dk one-cycle pulse, no uk_valid. clear coincident with tick -> no CAP, overrun stays 0.
- With PID_UK_RATE_LIMIT_EN, uk_prev=0, target sum=60, RATE_MAX=16 -> uk=16, 32, 48, 60 on successive samples. Without the macro -> uk=60 on the first sample.
